mc_control: RTL and testbench

- Multicycle control sequencer for the MIPS datapath. It replaces the single-cycle combinational control with a state machine that steps each instruction through fetch, decode, execute, memory and writeback.
- It shares one memory port between instruction fetch and data access using a ready handshake.
- It drives all datapath mux selects and write enables, counts retired instructions and flags illegal opcodes and memory timeouts.

---
 rtl/mips_defs_pkg.sv | 100 ++++++++++
 rtl/mc_wait_timer.sv | 29 ++
 rtl/mc_control.sv | 214 +++++++++++++++++++++
 tb/tb_mc_control.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS control definitions: FSM state codes, opcode/funct values,
// ALU op and datapath mux-select encodings, and the control-word struct.
package mips_defs;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_WB_R     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_WB_I     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;
  localparam logic [3:0] S_HALT     = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_RS = 1'b1;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // State that follows DECODE; S_HALT means the instruction is unsupported.
  function automatic logic [3:0] decode_next(input logic [5:0] opcode,
                                             input logic [5:0] funct);
    logic [3:0] nxt;
    nxt = S_HALT;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR:                                 nxt = S_JR;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = S_EXEC_R;
          default:                               nxt = S_HALT;
        endcase
      end
      OP_LW, OP_SW:   nxt = S_MEM_ADDR;
      OP_ADDI:        nxt = S_EXEC_I;
      OP_BEQ, OP_BNE: nxt = S_BRANCH;
      OP_J:           nxt = S_JUMP;
      OP_JAL:         nxt = S_JAL;
      default:        nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles in a memory state and flags
// when the count has reached TIMEOUT (never, when TIMEOUT is 0).
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic cnt,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (cnt) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count_q == W'(TIMEOUT));

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module mc_control
  import mips_defs::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  // Memory handshake: mem_read/mem_write is a request held steady until
  // mem_ready; the access completes in the cycle where both are high.
  logic [3:0]       state_q, state_d;
  logic [5:0]       op_q;
  logic             illegal_q, bus_error_q;
  logic [CNT_W-1:0] retired_q;
  logic             set_illegal, set_bus_error, retire;
  logic             wait_st, timer_clr, timer_cnt, expired;
  ctrl_t            ctrl, ctrl_out;

  assign wait_st   = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
  assign timer_clr = !wait_st || mem_ready;
  assign timer_cnt = wait_st && !mem_ready && !expired;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .cnt     (timer_cnt),
    .expired (expired)
  );

  always_comb begin
    ctrl          = '0;
    state_d       = state_q;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (expired) begin
          state_d       = S_HALT;
          set_bus_error = 1'b1;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        state_d        = decode_next(opcode, funct);
        set_illegal    = (state_d == S_HALT);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_WB_R;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = MTR_ALUOUT;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (state_q == S_EXEC_I) state_d = S_WB_I;
        else state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MTR_ALUOUT;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (expired) begin
          state_d       = S_HALT;
          set_bus_error = 1'b1;
        end
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MTR_MDR;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (expired) begin
          state_d       = S_HALT;
          set_bus_error = 1'b1;
        end
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = (op_q == OP_BEQ) ? zero : !zero;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so it is the link value.
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = MTR_PC;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_JR: begin
        ctrl.pc_source = PCSRC_RS;
        ctrl.pc_write  = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Only the opcode is needed after DECODE (lw/sw and beq/bne split later).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_error) bus_error_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Reset is asynchronous, so controls are masked combinationally as well.
  assign ctrl_out   = reset ? '0 : ctrl;
  assign pc_write   = ctrl_out.pc_write;
  assign ir_write   = ctrl_out.ir_write;
  assign iord       = ctrl_out.iord;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign reg_write  = ctrl_out.reg_write;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign pc_source  = ctrl_out.pc_source;
  assign halted     = !reset && (state_q == S_HALT);
  assign illegal    = illegal_q;
  assign bus_error  = bus_error_q;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction cycle schedules built from the
// instruction rules, compared against the DUT on every cycle.
module tb_mc_control;
  import mips_defs::*;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0]    reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic          alu_src_a, halted, illegal, bus_error;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  mc_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .halted(halted), .illegal(illegal),
    .bus_error(bus_error), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, irw, iord, mr, mw, rw;
    logic [1:0] rd, mtr;
    logic asa;
    logic [1:0] asb, aop, psrc;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic [3:0] st;
    logic halted, illegal, bus_error;
    logic [CW-1:0] retired;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  logic halt_m = 1'b0, ill_m = 1'b0, bus_m = 1'b0;
  logic [CW-1:0] ret_m = '0;

  function automatic ctl_t mk(input logic pcw, irw, io, mr, mw, rw,
                              input logic [1:0] rd, mtr, input logic asa,
                              input logic [1:0] asb, aop, psrc);
    return {pcw, irw, io, mr, mw, rw, rd, mtr, asa, asb, aop, psrc};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  always @(negedge clk) begin
    exp_t e, g;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g.c = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
      g.st = state;
      g.halted = halted;
      g.illegal = illegal;
      g.bus_error = bus_error;
      g.retired = retired;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL cycle t=%0t got st=%0d ctl=%h hib=%b%b%b ret=%0d exp st=%0d ctl=%h hib=%b%b%b ret=%0d",
                 $time, g.st, g.c, g.halted, g.illegal, g.bus_error, g.retired,
                 e.st, e.c, e.halted, e.illegal, e.bus_error, e.retired);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, record what this cycle must show.
  task automatic step(input logic [3:0] st, input ctl_t c, input logic rdy,
                      input logic z, input logic ret, input logic [5:0] op,
                      input logic [5:0] fn);
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = rdy; zero = z; opcode = op; funct = fn;
    e.c = c; e.st = st; e.halted = halt_m; e.illegal = ill_m;
    e.bus_error = bus_m; e.retired = ret_m;
    exp_q.push_back(e);
    if (ret) ret_m = ret_m + 1'b1;
    ncyc++;
  endtask

  task automatic rst_cycle();
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = rb(); zero = rb(); opcode = r6(); funct = r6();
    halt_m = 1'b0; ill_m = 1'b0; bus_m = 1'b0; ret_m = '0;
    e = '0;
    e.st = S_FETCH;
    exp_q.push_back(e);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) step(S_HALT, '0, rb(), rb(), 1'b0, r6(), r6());
  endtask

  // n stalled cycles; more than TO stalls means the access times out.
  task automatic wait_phase(input logic [3:0] st, input ctl_t c, input int n, output bit ok);
    ok = 1'b1;
    if (n <= TO) begin
      for (int i = 0; i < n; i++) step(st, c, 1'b0, rb(), 1'b0, r6(), r6());
    end else begin
      for (int i = 0; i <= TO; i++) step(st, c, 1'b0, rb(), 1'b0, r6(), r6());
      bus_m = 1'b1; halt_m = 1'b1; ok = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z);
    bit ok;
    ctl_t fet, mrd, mwr, addr;
    fet  = mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00);
    mrd  = mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    mwr  = mk(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    addr = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b00);
    ncyc = 0;
    wait_phase(S_FETCH, fet, fw, ok);
    if (!ok) return;
    fet.pcw = 1'b1; fet.irw = 1'b1;
    step(S_FETCH, fet, 1'b1, rb(), 1'b0, r6(), r6());
    step(S_DECODE, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00),
         rb(), rb(), 1'b0, op, fn);
    if (op == OP_RTYPE && fn == FN_JR) begin
      step(S_JR, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11), rb(), rb(), 1'b1, r6(), r6());
    end else if (op == OP_RTYPE && fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
      step(S_EXEC_R, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b10, 2'b00), rb(), rb(), 1'b0, r6(), r6());
      step(S_WB_R, mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00), rb(), rb(), 1'b1, r6(), r6());
    end else if (op == OP_ADDI) begin
      step(S_EXEC_I, addr, rb(), rb(), 1'b0, r6(), r6());
      step(S_WB_I, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00), rb(), rb(), 1'b1, r6(), r6());
    end else if (op == OP_LW) begin
      step(S_MEM_ADDR, addr, rb(), rb(), 1'b0, r6(), r6());
      wait_phase(S_MEM_RD, mrd, mw, ok);
      if (!ok) return;
      step(S_MEM_RD, mrd, 1'b1, rb(), 1'b0, r6(), r6());
      step(S_WB_MEM, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00), rb(), rb(), 1'b1, r6(), r6());
    end else if (op == OP_SW) begin
      step(S_MEM_ADDR, addr, rb(), rb(), 1'b0, r6(), r6());
      wait_phase(S_MEM_WR, mwr, mw, ok);
      if (!ok) return;
      step(S_MEM_WR, mwr, 1'b1, rb(), 1'b1, r6(), r6());
    end else if (op == OP_BEQ || op == OP_BNE) begin
      step(S_BRANCH, mk((op == OP_BEQ) ? z : !z, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b01),
           rb(), z, 1'b1, r6(), r6());
    end else if (op == OP_J) begin
      step(S_JUMP, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b10), rb(), rb(), 1'b1, r6(), r6());
    end else if (op == OP_JAL) begin
      step(S_JAL, mk(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 2'b10), rb(), rb(), 1'b1, r6(), r6());
    end else begin
      ill_m = 1'b1; halt_m = 1'b1;
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return TO + 1;
    if (r < 4) return TO;
    return $urandom_range(0, 2);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int k;
    repeat (2) rst_cycle();

    run_instr(OP_RTYPE, FN_ADD, 0, 0, 1'b0);
    lit("add_cycles", ncyc, 4);
    lit("add_retired", 32'(ret_m), 1);
    run_instr(OP_LW, r6(), 0, 2, 1'b0);
    lit("lw_wait2_cycles", ncyc, 7);
    run_instr(OP_BEQ, r6(), 0, 0, 1'b1);
    lit("beq_cycles", ncyc, 3);
    run_instr(OP_BNE, r6(), 0, 0, 1'b1);
    lit("bne_cycles", ncyc, 3);
    run_instr(OP_JAL, r6(), 0, 0, 1'b0);
    lit("jal_cycles", ncyc, 3);
    run_instr(OP_SW, r6(), 0, 0, 1'b0);
    lit("sw_cycles", ncyc, 4);
    run_instr(OP_J, r6(), TO, 0, 1'b0);
    lit("fetch_wait_to_cycles", ncyc, TO + 3);
    run_instr(OP_SW, r6(), 0, TO, 1'b0);
    lit("sw_wait_to_cycles", ncyc, TO + 4);

    run_instr(6'b111111, r6(), 0, 0, 1'b0);
    lit("illegal_model", 32'(ill_m), 1);
    halt_cycles(3);
    rst_cycle();

    run_instr(OP_ADDI, r6(), TO + 1, 0, 1'b0);
    lit("timeout_cycles", ncyc, TO + 1);
    halt_cycles(2);
    rst_cycle();
    run_instr(OP_LW, r6(), 0, TO + 1, 1'b0);
    halt_cycles(2);
    rst_cycle();

    for (int i = 0; i < 17; i++) run_instr(OP_J, r6(), 0, 0, 1'b0);
    lit("retired_wrap_model", 32'(ret_m), 1);

    step(S_FETCH, mk(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00), 1'b1, 1'b0, 1'b0, r6(), r6());
    step(S_DECODE, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00), 1'b0, 1'b0, 1'b0, OP_SW, r6());
    step(S_MEM_ADDR, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b00), 1'b0, 1'b0, 1'b0, r6(), r6());
    step(S_MEM_WR, mk(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00), 1'b0, 1'b0, 1'b0, r6(), r6());
    @(negedge clk); #1;
    lit("mem_write_held", 32'(mem_write), 1);
    reset = 1'b1;
    #1;
    lit("mem_write_reset_drop", 32'(mem_write), 0);
    lit("state_reset", 32'(state), 32'(S_FETCH));
    rst_cycle();

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 13);
      fn = r6();
      case (k)
        0: begin op = OP_RTYPE; fn = FN_ADD; end
        1: begin op = OP_RTYPE; fn = FN_SUB; end
        2: begin op = OP_RTYPE; fn = FN_AND; end
        3: begin op = OP_RTYPE; fn = FN_OR; end
        4: begin op = OP_RTYPE; fn = FN_SLT; end
        5: begin op = OP_RTYPE; fn = FN_JR; end
        6: op = OP_J;
        7: op = OP_JAL;
        8: op = OP_BEQ;
        9: op = OP_BNE;
        10: op = OP_ADDI;
        11: op = OP_LW;
        12: op = OP_SW;
        default: begin
          case ($urandom_range(0, 2))
            0: op = 6'b111111;
            1: op = 6'b001100;
            default: begin op = OP_RTYPE; fn = 6'b100111; end
          endcase
        end
      endcase
      run_instr(op, fn, pick_wait(), pick_wait(), rb());
      if (halt_m) begin
        halt_cycles($urandom_range(1, 3));
        rst_cycle();
      end
    end

    run_instr(OP_J, r6(), 0, 0, 1'b0);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
